la_capture_engine: RTL and testbench

//  Upstream producer for capture playback: samples the concatenated probe bus every clk,

---
 rtl/la_pkg.sv | 21 ++
 rtl/la_sample_ram.sv | 27 ++
 rtl/la_capture_engine.sv | 131 +++++++++++++
 tb/tb_la_capture_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared types, state encodings and modular-address helper for the logic-analyser capture engine.
package la_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE        = 3'd0;
    localparam state_t MOVE_TO_POS = 3'd1;
    localparam state_t IN_POSITION = 3'd2;
    localparam state_t CAPTURING   = 3'd3;
    localparam state_t CAPTURED    = 3'd4;

    // (a + b) mod depth, valid when a < depth and b <= depth; works for any depth.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned depth);
        int unsigned s;
        s = a + b;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no array reset.
module la_sample_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 7,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/la_capture_engine.sv
// Trigger-driven capture into a circular sample RAM, with chronological window readout.
module la_capture_engine
    import la_pkg::*;
#(
    parameter int unsigned SAMPLE_DEPTH      = 4096,
    parameter int unsigned TOTAL_PROBE_WIDTH = 7,
    parameter int unsigned TRIGGER_LOC       = SAMPLE_DEPTH / 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TOTAL_PROBE_WIDTH-1:0]     probes,
    input  logic                             arm,
    input  logic                             abort,
    input  logic [TOTAL_PROBE_WIDTH-1:0]     trig_mask,
    input  logic [TOTAL_PROBE_WIDTH-1:0]     trig_value,
    input  logic                             trig_edge,
    output logic [2:0]                       state,
    output logic                             done,
    input  logic [$clog2(SAMPLE_DEPTH)-1:0]  rd_addr,
    output logic [TOTAL_PROBE_WIDTH-1:0]     rd_data
);

    localparam int unsigned AW = $clog2(SAMPLE_DEPTH);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLE_DEPTH - 1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(TRIGGER_LOC - 1);
    localparam logic [AW-1:0] POST_INIT = AW'(SAMPLE_DEPTH - TRIGGER_LOC - 1);

    state_t                       state_q;
    logic [AW-1:0]                wptr;
    logic [AW-1:0]                wptr_inc;
    logic [AW-1:0]                start_ptr;
    logic [AW-1:0]                pre_cnt;
    logic [AW-1:0]                post_cnt;
    logic                         match;
    logic                         match_q;
    logic                         fire;
    logic                         we;
    logic [AW-1:0]                phys;
    logic                         rd_ok;
    logic                         rd_ok_q;
    logic [AW-1:0]                raddr;
    logic [TOTAL_PROBE_WIDTH-1:0] ram_q;

    assign match    = ((probes ^ trig_value) & trig_mask) == '0;
    assign fire     = trig_edge ? (match & ~match_q) : match;
    assign wptr_inc = (wptr == LAST_ADDR) ? '0 : (wptr + AW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wptr      <= '0;
            start_ptr <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            match_q   <= 1'b0;
        end else begin
            match_q <= match;
            if (abort) begin
                state_q <= IDLE;
            end else if (arm) begin
                wptr     <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
                state_q  <= (TRIGGER_LOC == 0) ? IN_POSITION : MOVE_TO_POS;
            end else begin
                case (state_q)
                    MOVE_TO_POS: begin
                        wptr    <= wptr_inc;
                        pre_cnt <= pre_cnt + AW'(1);
                        if (pre_cnt == PRE_LAST) begin
                            state_q <= IN_POSITION;
                        end
                    end
                    IN_POSITION: begin
                        wptr <= wptr_inc;
                        if (fire) begin
                            // Subtracting TRIGGER_LOC is done as adding its complement modulo depth.
                            start_ptr <= AW'(wrap_add(32'(wptr), SAMPLE_DEPTH - TRIGGER_LOC,
                                                      SAMPLE_DEPTH));
                            post_cnt  <= POST_INIT;
                            state_q   <= (POST_INIT == '0) ? CAPTURED : CAPTURING;
                        end
                    end
                    CAPTURING: begin
                        wptr     <= wptr_inc;
                        post_cnt <= post_cnt - AW'(1);
                        if (post_cnt == AW'(1)) begin
                            state_q <= CAPTURED;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign we = ~abort & ~arm &
                ((state_q == MOVE_TO_POS) | (state_q == IN_POSITION) | (state_q == CAPTURING));

    assign rd_ok = {1'b0, rd_addr} < (AW + 1)'(SAMPLE_DEPTH);
    assign phys  = AW'(wrap_add(32'(start_ptr), 32'(rd_addr), SAMPLE_DEPTH));
    assign raddr = rd_ok ? phys : '0;

    // Out-of-range reads and the reset value both come from this qualifier, not the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_ok;
        end
    end

    la_sample_ram #(
        .DEPTH (SAMPLE_DEPTH),
        .WIDTH (TOTAL_PROBE_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (probes),
        .raddr (raddr),
        .rdata (ram_q)
    );

    assign rd_data = rd_ok_q ? ram_q : '0;
    assign state   = state_q;
    assign done    = (state_q == CAPTURED);

endmodule

// File: tb/tb_la_capture_engine.sv
// Self-checking bench: three trigger-location variants share stimulus; windows checked via a scoreboard queue.
module tb_la_capture_engine;
    import la_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = 7;

    typedef struct {
        string      name;
        logic [6:0] mask;
        logic [6:0] value;
        logic       edge_mode;
        logic [6:0] arm_at;
        logic [6:0] base;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] cnt = '0;
    logic       hold = 1'b0;
    logic [6:0] hold_val = '0;
    logic [6:0] probes;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       trig_edge = 1'b0;
    logic [6:0] trig_mask = '0;
    logic [6:0] trig_value = '0;
    logic [3:0] rd_addr = '0;

    logic [2:0] state_m, state_0, state_15;
    logic       done_m, done_0, done_15;
    logic [6:0] rd_data_m, rd_data_0, rd_data_15;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [6:0] sb_q [$];
    logic [6:0] win [DEPTH];
    vec_t       vecs [5];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 7'd1;
    assign probes = hold ? hold_val : cnt;

    la_capture_engine #(.SAMPLE_DEPTH(DEPTH), .TOTAL_PROBE_WIDTH(W), .TRIGGER_LOC(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .probes(probes), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .state(state_m), .done(done_m), .rd_addr(rd_addr), .rd_data(rd_data_m));

    la_capture_engine #(.SAMPLE_DEPTH(DEPTH), .TOTAL_PROBE_WIDTH(W), .TRIGGER_LOC(0)) u_dut_t0 (
        .clk(clk), .rst_n(rst_n), .probes(probes), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .state(state_0), .done(done_0), .rd_addr(rd_addr), .rd_data(rd_data_0));

    la_capture_engine #(.SAMPLE_DEPTH(DEPTH), .TOTAL_PROBE_WIDTH(W), .TRIGGER_LOC(15)) u_dut_t15 (
        .clk(clk), .rst_n(rst_n), .probes(probes), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .state(state_15), .done(done_15), .rd_addr(rd_addr), .rd_data(rd_data_15));

    function automatic logic [6:0] rd_of(input int sel);
        case (sel)
            0:       return rd_data_m;
            1:       return rd_data_0;
            default: return rd_data_15;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_m;
            1:       return done_0;
            default: return done_15;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input logic [6:0] target);
        for (int k = 0; k < 300; k++) begin
            if (cnt == target) break;
            tick(1);
        end
        if (cnt != target) check("wait_cnt timeout", 32'(cnt), 32'(target));
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic wait_done(input int sel, input string tag);
        for (int k = 0; k < 400; k++) begin
            if (done_of(sel)) break;
            tick(1);
        end
        check({tag, " done"}, 32'(done_of(sel)), 32'd1);
    endtask

    task automatic fill_ramp(input logic [6:0] base);
        for (int i = 0; i < int'(DEPTH); i++) win[i] = base + 7'(i);
    endtask

    // Expected samples are queued with each address and retired when rd_data appears.
    task automatic read_window(input int sel, input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_addr = 4'(i);
            sb_q.push_back(win[i]);
            tick(1);
            check($sformatf("%s rd%0d", tag, i), 32'(rd_of(sel)), 32'(sb_q.pop_front()));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"level20",   7'h7F, 7'd20, 1'b0, 7'd0,  7'd16};
        vecs[1] = '{"move_ign",  7'h7F, 7'd2,  1'b0, 7'd0,  7'd126};
        vecs[2] = '{"mask0",     7'h00, 7'd0,  1'b0, 7'd10, 7'd11};
        vecs[3] = '{"nibble",    7'h0F, 7'd3,  1'b0, 7'd0,  7'd15};
        vecs[4] = '{"edge_ramp", 7'h7F, 7'd40, 1'b1, 7'd0,  7'd36};

        #2;
        check("reset state", 32'(state_m), 32'(IDLE));
        check("reset done", 32'(done_m), 32'd0);
        check("reset rd_data", 32'(rd_data_m), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        check("idle after reset", 32'(state_m), 32'(IDLE));

        foreach (vecs[v]) begin
            trig_mask  = vecs[v].mask;
            trig_value = vecs[v].value;
            trig_edge  = vecs[v].edge_mode;
            hold       = 1'b0;
            wait_cnt(vecs[v].arm_at);
            do_arm();
            check({vecs[v].name, " armed"}, 32'(state_m), 32'(MOVE_TO_POS));
            wait_done(0, vecs[v].name);
            check({vecs[v].name, " state"}, 32'(state_m), 32'(CAPTURED));
            fill_ramp(vecs[v].base);
            read_window(0, vecs[v].name);
        end

        // Trigger-location extremes: trigger lands at rd 0 and rd 15.
        trig_mask = 7'h7F; trig_value = 7'd20; trig_edge = 1'b0;
        wait_cnt(7'd0);
        do_arm();
        check("t0 skips move", 32'(state_0), 32'(IN_POSITION));
        wait_done(0, "loc4");
        wait_done(1, "loc0");
        wait_done(2, "loc15");
        fill_ramp(7'd16); read_window(0, "loc4");
        fill_ramp(7'd20); read_window(1, "loc0");
        fill_ramp(7'd5);  read_window(2, "loc15");

        // Edge mode with probes already matching before arm.
        hold = 1'b1; hold_val = 7'd5;
        trig_value = 7'd5; trig_edge = 1'b1;
        tick(3);
        do_arm();
        tick(30);
        check("edge held no fire", 32'(state_m), 32'(IN_POSITION));
        check("edge held done", 32'(done_m), 32'd0);
        hold_val = 7'd6;
        tick(1);
        hold_val = 7'd5;
        tick(1);
        check("edge refire", 32'(state_m), 32'(CAPTURING));
        wait_done(0, "edge_held");
        for (int i = 0; i < int'(DEPTH); i++) win[i] = (i == 3) ? 7'd6 : 7'd5;
        read_window(0, "edge_held");

        // Level mode on held probes fires on the first IN_POSITION cycle.
        trig_edge = 1'b0;
        do_arm();
        tick(4);
        check("level enter pos", 32'(state_m), 32'(IN_POSITION));
        tick(1);
        check("level first fire", 32'(state_m), 32'(CAPTURING));
        tick(10);
        check("level still cap", 32'(state_m), 32'(CAPTURING));
        tick(1);
        check("level captured", 32'(state_m), 32'(CAPTURED));

        // Abort and arm/abort precedence.
        hold = 1'b0; trig_mask = 7'h00;
        do_arm();
        tick(8);
        check("pre-abort", 32'(state_m), 32'(CAPTURING));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort state", 32'(state_m), 32'(IDLE));
        check("abort done", 32'(done_m), 32'd0);
        do_arm();
        check("rearm", 32'(state_m), 32'(MOVE_TO_POS));
        arm = 1'b1; abort = 1'b1;
        tick(1);
        arm = 1'b0; abort = 1'b0;
        check("arm+abort", 32'(state_m), 32'(IDLE));
        do_arm();
        wait_done(0, "pre-restart");
        do_arm();
        check("arm from captured", 32'(state_m), 32'(MOVE_TO_POS));
        check("arm clears done", 32'(done_m), 32'd0);

        // Asynchronous reset in the middle of CAPTURING.
        hold = 1'b1; hold_val = 7'h55; rd_addr = 4'd2;
        do_arm();
        tick(8);
        check("pre-reset state", 32'(state_m), 32'(CAPTURING));
        check("pre-reset rd", 32'(rd_data_m), 32'h55);
        rst_n = 1'b0;
        #2;
        check("async rst state", 32'(state_m), 32'(IDLE));
        check("async rst done", 32'(done_m), 32'd0);
        check("async rst rd", 32'(rd_data_m), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        check("post-reset idle", 32'(state_m), 32'(IDLE));
        check("ram kept", 32'(rd_data_m), 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
